// File: rtl/beat_clock_pkg.sv
// Shared types and constants for the beat clock generator.
// Divider FSM states, tempo constants, width helpers.
package beat_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned BPM_W       = 8;

  // Cycles per minute: numerator of the period division.
  function automatic longint unsigned num_of(
    input longint unsigned clk_hz
  );
    return clk_hz * 64'(SEC_PER_MIN);
  endfunction

  // Index width for a modulus n, never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Caller guarantees num[NUM_W-1:Q_W] < den so the quotient fits.
module seq_divider
  import beat_clock_pkg::*;
#(
  parameter int NUM_W = 42,
  parameter int DEN_W = 10,
  localparam int Q_W  = NUM_W - DEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [Q_W-1:0]   quot,
  output logic             done,
  output logic             busy
);

  localparam int CW = idx_w(Q_W);

  div_state_e       state;
  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_q;
  logic [Q_W-1:0]   q;
  logic [CW-1:0]    cnt;

  logic [DEN_W:0]   rem_sh;
  logic             ge;
  logic [DEN_W-1:0] rem_nx;

  // Trial subtraction for the next quotient bit.
  always_comb begin
    rem_sh = {rem, q[Q_W-1]};
    ge     = rem_sh >= {1'b0, den_q};
    rem_nx = ge ? DEN_W'(rem_sh - {1'b0, den_q})
                : rem_sh[DEN_W-1:0];
  end

  // Divider sequencing: load, Q_W bit steps, one done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rem   <= '0;
      den_q <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            rem   <= num[NUM_W-1:Q_W];
            q     <= num[Q_W-1:0];
            den_q <= den;
            cnt   <= '0;
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            rem <= rem_nx;
            q   <= {q[Q_W-2:0], ge};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(Q_W - 1))
              state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign quot = q;
  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/beat_clock_gen.sv
// BPM-driven metronome: tick/beat/bar pulses and indices.
// New periods land on tick boundaries so no tick is cut short.
module beat_clock_gen
  import beat_clock_pkg::*;
#(
  parameter longint unsigned CLK_HZ = 200_000_000,
  parameter int SUBDIV        = 4,
  parameter int BEATS_PER_BAR = 4,
  parameter int PERIOD_W      = 32,
  localparam int TW = idx_w(SUBDIV),
  localparam int BW = idx_w(BEATS_PER_BAR)
) (
  input  logic                clk_camera_in,
  input  logic                rst_n_in,
  input  logic [7:0]          bpm_in,
  input  logic                enable_in,
  input  logic                sync_in,
  output logic                tick_out,
  output logic                beat_out,
  output logic                bar_out,
  output logic [TW-1:0]       tick_idx_out,
  output logic [BW-1:0]       beat_idx_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic                busy_out
);

  localparam int SD_SH = $clog2(SUBDIV);
  localparam int DEN_W = BPM_W + SD_SH;
  localparam int NUM_W = PERIOD_W + DEN_W;
  localparam longint unsigned NUM = num_of(CLK_HZ);
  localparam logic [NUM_W-1:0] NUM_V = NUM_W'(NUM);

  if (NUM / 64'(SUBDIV) >= (64'd1 << PERIOD_W)) begin : g_bad_pw
    $error("PERIOD_W too small for CLK_HZ*60/SUBDIV");
  end
  if ((SUBDIV & (SUBDIV - 1)) != 0) begin : g_bad_sub
    $error("SUBDIV must be a power of two");
  end

  logic [BPM_W-1:0]    bpm_lat_q;
  logic [DEN_W-1:0]    den;
  logic [PERIOD_W-1:0] quot;
  logic                div_done;
  logic                div_busy;
  logic                bpm_diff;
  logic                div_start;
  logic                div_abort;
  logic                zero_load;

  logic                new_val;
  logic [PERIOD_W-1:0] new_per;
  logic                have_p;
  logic [PERIOD_W-1:0] p_val;
  logic                imm;
  logic                hold;
  logic                restart;
  logic                wrap;

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] pend_q;
  logic                pend_v_q;
  logic                restart_q;
  logic                en_q;
  logic [TW-1:0]       tick_idx_q;
  logic [TW-1:0]       tick_nx;
  logic [BW-1:0]       beat_idx_q;
  logic [BW-1:0]       beat_nx;
  logic                tick_wrap;
  logic                beat_wrap;
  logic                tick_q;
  logic                beat_q;
  logic                bar_q;

  // Launch, abort and zero-tempo decisions plus apply rules.
  always_comb begin
    bpm_diff  = (bpm_in != bpm_lat_q);
    div_start = !div_busy && bpm_diff && (bpm_in != '0);
    div_abort = div_busy && bpm_diff;
    zero_load = !div_busy && bpm_diff && (bpm_in == '0);
    den       = DEN_W'(bpm_in) << SD_SH;
    new_val   = (div_done && !div_abort) || zero_load;
    new_per   = zero_load ? '0 : quot;
    have_p    = new_val || pend_v_q;
    p_val     = new_val ? new_per : pend_q;
    imm       = have_p && ((period_q == '0) ||
                (p_val == '0) || !enable_in);
    hold      = !enable_in || (period_q == '0) ||
                (imm && (p_val == '0));
    restart   = restart_q || (enable_in && !en_q) || sync_in;
    wrap      = (cnt_q == period_q - PERIOD_W'(1));
    tick_wrap = (tick_idx_q == TW'(SUBDIV - 1));
    tick_nx   = tick_wrap ? '0 : tick_idx_q + TW'(1);
    beat_wrap = (beat_idx_q == BW'(BEATS_PER_BAR - 1));
    beat_nx   = beat_idx_q;
    if (tick_wrap)
      beat_nx = beat_wrap ? '0 : beat_idx_q + BW'(1);
  end

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk   (clk_camera_in),
    .rst_n (rst_n_in),
    .start (div_start),
    .abort (div_abort),
    .num   (NUM_V),
    .den   (den),
    .quot  (quot),
    .done  (div_done),
    .busy  (div_busy)
  );

  // Remember which tempo the divider is working on.
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in)
      bpm_lat_q <= '0;
    else if (!div_busy && bpm_diff)
      bpm_lat_q <= bpm_in;
  end

  // Active period: immediate when idle, else at the wrap.
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else if (imm) begin
      period_q <= p_val;
      pend_v_q <= 1'b0;
    end else if (have_p && wrap && !restart) begin
      period_q <= p_val;
      pend_v_q <= 1'b0;
    end else if (new_val) begin
      pend_q   <= new_per;
      pend_v_q <= 1'b1;
    end
  end

  // Tick counter, indices and registered pulses.
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q      <= '0;
      tick_idx_q <= '0;
      beat_idx_q <= '0;
      restart_q  <= 1'b0;
      en_q       <= 1'b0;
      tick_q     <= 1'b0;
      beat_q     <= 1'b0;
      bar_q      <= 1'b0;
    end else begin
      en_q   <= enable_in;
      tick_q <= 1'b0;
      beat_q <= 1'b0;
      bar_q  <= 1'b0;
      if (hold) begin
        cnt_q      <= '0;
        tick_idx_q <= '0;
        beat_idx_q <= '0;
        restart_q  <= imm && (p_val != '0) && enable_in;
      end else if (restart) begin
        cnt_q      <= '0;
        tick_idx_q <= '0;
        beat_idx_q <= '0;
        restart_q  <= 1'b0;
        tick_q     <= 1'b1;
        beat_q     <= 1'b1;
        bar_q      <= 1'b1;
      end else if (wrap) begin
        cnt_q      <= '0;
        tick_idx_q <= tick_nx;
        beat_idx_q <= beat_nx;
        tick_q     <= 1'b1;
        beat_q     <= tick_wrap;
        bar_q      <= tick_wrap && (beat_nx == '0);
      end else begin
        cnt_q <= cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign tick_out     = tick_q;
  assign beat_out     = beat_q;
  assign bar_out      = bar_q;
  assign tick_idx_out = tick_idx_q;
  assign beat_idx_out = beat_idx_q;
  assign period_out   = period_q;
  assign busy_out     = div_busy;

endmodule
